// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between the load/store
// unit (port 0) and the host/loader (port 1).
//   - Combinational round-robin grant, at most one access per cycle.
//   - Host burst lock: up to MAX_LOCK back-to-back port-1 grants, then one
//     forced port-0 slot while port 0 is waiting.
//   - Read data registered (1-cycle latency); rdata holds when rvalid is low.
//   - err pulses the cycle after any access with addr >= DEPTH; such writes
//     are suppressed and such reads return 0.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   pX_req/we/addr/wdata, p1_lock   requester side
//   pX_gnt                          combinational grant
//   pX_rvalid/rdata, err            registered responses
//   mem_we/raddr/waddr/wdata        memory drive (winner's access, else 0)
//   mem_rdata                       memory asynchronous read data
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0]  MAX_LOCK_C = 8'(MAX_LOCK);
  localparam logic [31:0] DEPTH_C    = 32'(DEPTH);

  typedef enum logic {ARB, LOCKED} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;        // last winner: 0 = port 0, 1 = port 1
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        p0_rvalid_q, p0_rvalid_d;
  logic        p1_rvalid_q, p1_rvalid_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        in_range;

  // Grant selection
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    unique case (state_q)
      ARB: begin
        if (p0_req && p1_req) begin
          p0_gnt = last_q;
          p1_gnt = ~last_q;
        end else begin
          p0_gnt = p0_req;
          p1_gnt = p1_req;
        end
      end
      LOCKED: begin
        if (p1_req) begin
          // Port 1 keeps the memory until its lock budget is spent and
          // port 0 is actually waiting; then port 0 gets one slot.
          if ((lock_cnt_q < MAX_LOCK_C) || !p0_req) p1_gnt = 1'b1;
          else                                      p0_gnt = 1'b1;
        end else begin
          p0_gnt = p0_req;
        end
      end
      default: ;
    endcase
  end

  // Winner mux and memory drive
  always_comb begin
    accept    = p0_gnt | p1_gnt;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (p0_gnt) begin
      win_we    = p0_we;
      win_addr  = p0_addr;
      win_wdata = p0_wdata;
    end else if (p1_gnt) begin
      win_we    = p1_we;
      win_addr  = p1_addr;
      win_wdata = p1_wdata;
    end
    in_range  = win_addr < DEPTH_C;
    mem_we    = accept & win_we & in_range;
    mem_raddr = win_addr;
    mem_waddr = win_addr;
    mem_wdata = win_wdata;
  end

  // Next-state: arbitration state, lock counter, last winner
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_d     = last_q;
    if (accept) last_d = p1_gnt;
    unique case (state_q)
      ARB: begin
        if (p1_gnt && p1_lock) begin
          state_d    = LOCKED;
          lock_cnt_d = 8'd1;
        end
      end
      LOCKED: begin
        if (!p1_req) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else if (p1_gnt) begin
          if (p1_lock) begin
            lock_cnt_d = (lock_cnt_q >= MAX_LOCK_C) ? MAX_LOCK_C : lock_cnt_q + 8'd1;
          end else begin
            state_d    = ARB;
            lock_cnt_d = '0;
          end
        end else if (p0_gnt) begin
          lock_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Response path
  always_comb begin
    p0_rvalid_d = p0_gnt & ~p0_we;
    p1_rvalid_d = p1_gnt & ~p1_we;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    if (p0_rvalid_d) p0_rdata_d = in_range ? mem_rdata : '0;
    if (p1_rvalid_d) p1_rdata_d = in_range ? mem_rdata : '0;
    err_d = accept & ~in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      last_q      <= 1'b1;
      lock_cnt_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lock_cnt_q  <= lock_cnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      err_q       <= err_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign err       = err_q;

endmodule
